// File: rtl/aes_inv_ctrl_pkg.sv
// Shared types and constants for the AES-128 inverse cipher job sequencer.
package aes_inv_ctrl_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;
  localparam int KEXP_LAT  = 12;
  localparam int DEC_LAT   = 12;
  localparam int WDOG_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    KLOAD,
    KWAIT,
    DLOAD,
    DWAIT,
    OUT
  } aes_inv_ctrl_state_t;

endpackage

// File: rtl/aes_inv_ctrl_if.sv
// Job port of the inverse cipher sequencer: {key, ciphertext} in, plaintext/error out.
interface aes_inv_ctrl_if;
  import aes_inv_ctrl_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [AES_KEY_W-1:0] in_key;
  logic [AES_BLK_W-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [AES_BLK_W-1:0] out_data;
  logic                 out_err;

  modport master (
    output in_valid, in_key, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_key, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/aes_inv_ctrl.sv
// Job-level sequencer for the AES-128 inverse cipher core, with a stall watchdog.
// Define AES_INV_CTRL_KEYCACHE_EN to skip key expansion when the job key matches the last expanded key.
module aes_inv_ctrl
  import aes_inv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 31  // legal range 13..255
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_ctrl_if.slave        job,
  output logic                 busy,
  output logic                 core_kld,
  output logic                 core_ld,
  output logic [AES_KEY_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_text_in,
  input  logic                 core_kdone,
  input  logic                 core_done,
  input  logic [AES_BLK_W-1:0] core_text_out
);

  aes_inv_ctrl_state_t  state_q, state_d;
  logic [WDOG_W-1:0]    wdog_q;
  logic                 key_vld_q;
  logic                 err_q;
  logic [AES_BLK_W-1:0] out_data_q;
  logic                 accept;
  logic                 key_hit;
  logic                 wdog_expired;

  assign accept = (state_q == IDLE) && job.in_valid;

  // The TIMEOUT-th consecutive cycle in a wait state without completion aborts the job.
  assign wdog_expired = (wdog_q >= WDOG_W'(TIMEOUT - 1));

`ifdef AES_INV_CTRL_KEYCACHE_EN
  logic [AES_KEY_W-1:0] cache_key_q;

  assign key_hit = key_vld_q && (job.in_key == cache_key_q);

  // NOTE: the cached key has no reset; key_vld_q is the only thing that makes it meaningful.
  always_ff @(posedge clk) begin
    if ((state_q == KWAIT) && core_kdone) cache_key_q <= core_key;
  end
`else
  assign key_hit = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    job.in_ready  = (state_q == IDLE);
    job.out_valid = (state_q == OUT);
    job.out_data  = out_data_q;
    job.out_err   = err_q;
    busy          = (state_q != IDLE);
    core_kld      = (state_q == KLOAD);
    core_ld       = (state_q == DLOAD) && key_vld_q;
    unique case (state_q)
      IDLE:    if (job.in_valid) state_d = key_hit ? DLOAD : KLOAD;
      KLOAD:   state_d = KWAIT;
      KWAIT:   if (core_kdone || wdog_expired) state_d = core_kdone ? DLOAD : OUT;
      DLOAD:   state_d = DWAIT;
      DWAIT:   if (core_done || wdog_expired) state_d = OUT;
      OUT:     if (job.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      key_vld_q    <= 1'b0;
      err_q        <= 1'b0;
      out_data_q   <= '0;
      core_key     <= '0;
      core_text_in <= '0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q) begin
        wdog_q <= '0;
      end else if (((state_q == KWAIT) || (state_q == DWAIT)) && (wdog_q != '1)) begin
        wdog_q <= wdog_q + 1'b1;
      end

      if (accept) begin
        core_key     <= job.in_key;
        core_text_in <= job.in_data;
        err_q        <= 1'b0;
      end

      unique case (state_q)
        KLOAD: key_vld_q <= 1'b0;
        KWAIT: begin
          if (core_kdone) begin
            key_vld_q <= 1'b1;
          end else if (wdog_expired) begin
            key_vld_q  <= 1'b0;
            err_q      <= 1'b1;
            out_data_q <= '0;
          end
        end
        DWAIT: begin
          if (core_done) begin
            out_data_q <= core_text_out;
          end else if (wdog_expired) begin
            err_q      <= 1'b1;
            out_data_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_inv_ctrl.md
# aes_inv_ctrl

Job-level sequencer for the AES-128 inverse cipher core. Accepts {key, ciphertext} jobs on a valid/ready port, issues the core's key-load and block-load pulses in the correct order, waits on the core's completion flags, and returns plaintext on a backpressured valid/ready port. Optionally skips key re-expansion when the job key matches the last expanded key. Includes a watchdog that reports a stalled core.

## Interface
- TIMEOUT, 31: maximum cycles spent waiting for `core_kdone` or `core_done` before the job errors; range 13..255.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  job offered
- in_ready  out  1  controller can accept a job; high only in IDLE
- in_key  in  128  cipher key
- in_data  in  128  ciphertext block
- out_valid  out  1  result held until accepted
- out_ready  in  1  consumer accepts result
- out_data  out  128  plaintext; zero on error
- out_err  out  1  job aborted by watchdog, qualified by out_valid
- busy  out  1  state != IDLE
- core_kld  out  1  one-cycle key-load pulse to the core
- core_ld  out  1  one-cycle block-load pulse to the core
- core_key  out  128  registered key, stable from KLOAD until the next accepted miss
- core_text_in  out  128  registered ciphertext
- core_kdone  in  1  level; low from the cycle after `core_kld` until expansion completes
- core_done  in  1  one-cycle pulse; `core_text_out` is valid in the same cycle
- core_text_out  in  128  plaintext from the core

## Operation
- States: IDLE, KLOAD, KWAIT, DLOAD, DWAIT, OUT.
- IDLE: `in_ready=1`. On `in_valid`, register `in_key` into `core_key` and `in_data` into `core_text_in`, and clear the watchdog.
  - Key hit (cache enabled): go to DLOAD.
  - Otherwise: go to KLOAD.
- KLOAD: `core_kld=1` for one cycle, clear `key_vld`, then go to KWAIT.
- KWAIT: when `core_kdone=1`, set `key_vld`, store the cached key, and go to DLOAD. If the watchdog reaches TIMEOUT, set the error, clear `key_vld`, and go to OUT.
- DLOAD: `core_ld=1` for one cycle, then go to DWAIT.
- DWAIT: when `core_done=1`, capture `core_text_out` into `out_data` and go to OUT. If the watchdog reaches TIMEOUT, go to OUT with `out_err=1` and `out_data=0`.
- OUT: `out_valid=1`, with data and err held stable. When `out_ready=1`, go to IDLE.
- Watchdog:
  - 8-bit counter, increments in KWAIT and DWAIT, cleared on every state change.
  - Saturates and never wraps.
- `core_kld` and `core_ld` are never asserted in the same cycle. `core_ld` is never asserted while `key_vld=0`.
- Reset, including mid-job: state=IDLE and `key_vld=0`. The job in flight is dropped with no response. The core shares `rst`.

## Timing
- Reset values: `in_ready=1`; `busy=0`, `out_valid=0`, `out_err=0`, `core_kld=0`, `core_ld=0`; `out_data=0`, `core_key=0`, `core_text_in=0`.
- Cycle 0 is the accept cycle.
- Key miss:
  - `core_kld` in cycle 1.
  - `core_kdone` rises in cycle 13.
  - `core_ld` in cycle 14.
  - `core_done` in cycle 26.
  - `out_valid` from cycle 27.
- Key hit: `core_ld` in cycle 1, `core_done` in cycle 13, `out_valid` from cycle 14.
- Back-to-back hits: next accept no earlier than the cycle after the `out_valid&out_ready` handshake. Throughput is 1 block per 15 cycles.
- Simultaneous `in_valid` and an OUT handshake: the new job is not accepted that cycle because `in_ready` is low in OUT.
- `core_done` outside DWAIT, or `core_kdone` edges outside KWAIT, are ignored.

## Configuration
- `AES_INV_CTRL_KEYCACHE_EN` defined:
  - A 128-bit cached key plus `key_vld` are kept.
  - A job whose `in_key` equals the cached key while `key_vld=1` skips KLOAD/KWAIT.
- Undefined: every job passes through KLOAD/KWAIT, and there is no cache register. `key_vld` still gates `core_ld`.

## Structure
- Package `aes_inv_ctrl_pkg`: state enum `aes_inv_ctrl_state_t`, `AES_BLK_W=128`, `AES_KEY_W=128`, core latency constants (`KEXP_LAT=12`, `DEC_LAT=12`).
- Single module, no sub-modules. The watchdog counter stays inline.

## Test plan
- Key miss: key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a → `out_data` 00112233445566778899aabbccddeeff, `out_err=0`, `out_valid` at cycle 27.
- Same key repeated with the same data: with the cache macro, `core_kld` is not pulsed and `out_valid` is at cycle 14. Without the macro, `core_kld` is pulsed and `out_valid` is at cycle 27.
- Backpressure: `out_ready=0` for 20 cycles → `out_valid`/`out_data` stable, `in_ready=0`; the result is released on the first `out_ready=1`.
- Stub core with `core_done` tied to 0 → after TIMEOUT=31 cycles in DWAIT: `out_valid=1`, `out_err=1`, `out_data=0`.
- `rst=0` asserted in cycle 5 of a miss job → next cycle IDLE, `in_ready=1`, `out_valid=0`. The following same-key job takes the miss path.
- Alternate keys A/B/A with the cache enabled → three `core_kld` pulses, all three results correct.
